// File: rtl/vis_byte_streamer_if.sv
// rtl/vis_byte_streamer_if.sv - visibility word bus and output byte stream bundle
interface vis_byte_streamer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] bus_revis_i;
    logic [WIDTH-1:0] bus_imvis_i;
    logic             bus_valid_i;
    logic             bus_ready_o;
    logic             bus_last_i;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [7:0]       m_tdata;

    // Streamer side: consumes visibility words, produces bytes
    modport slave (
        input  bus_revis_i,
        input  bus_imvis_i,
        input  bus_valid_i,
        input  bus_last_i,
        input  m_tready,
        output bus_ready_o,
        output m_tvalid,
        output m_tlast,
        output m_tdata
    );

    // Environment side: drives visibility words, sinks bytes
    modport master (
        output bus_revis_i,
        output bus_imvis_i,
        output bus_valid_i,
        output bus_last_i,
        output m_tready,
        input  bus_ready_o,
        input  m_tvalid,
        input  m_tlast,
        input  m_tdata
    );
endinterface

// File: rtl/vis_byte_streamer.sv
// rtl/vis_byte_streamer.sv - visibility words to framed byte stream with header and length check
module vis_byte_streamer #(
    parameter int         WIDTH = 32,
    parameter int         VIS_N = 6,
    parameter logic [7:0] SYNC  = 8'hA5,
    parameter int         FBITS = 16
) (
    input  logic                 bus_clock,
    input  logic                 areset_n,
    vis_byte_streamer_if.slave   bus,
    input  logic                 err_clear_i,
    output logic [FBITS-1:0]     frame_o,
    output logic                 error_o
);
    localparam int NB = 2 * WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int VW = $clog2(VIS_N + 1);
    localparam logic [BW-1:0] LAST_B  = BW'(NB - 1);
    localparam logic [VW-1:0] VCNT_LW = VW'(VIS_N - 1);
    localparam logic [VW-1:0] VCNT_SAT = VW'(VIS_N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [1:0]         hidx_q, hidx_d;
    logic               hdr_err_q, hdr_err_d;
    logic [2*WIDTH-1:0] hold_q, hold_d;
    logic [BW-1:0]      bidx_q, bidx_d;
    logic               full_q, full_d;
    logic               lat_last_q, lat_last_d;
    logic [VW-1:0]      vcnt_q, vcnt_d;
    logic [FBITS-1:0]   frame_q, frame_d;
    logic               error_q, error_d;

    logic               tvalid, tlast, bready;
    logic [7:0]         tdata;
    logic [15:0]        fr16;
    logic               byte_acc, word_acc, last_byte, err_set;

    assign fr16      = 16'(frame_q);
    assign last_byte = full_q && (bidx_q == LAST_B);

    // Output byte mux and ready; ready looks through to m_tready so words stream without bubbles.
    // Once the frame's final word is held, no further word is taken: the next frame needs its own header.
    always_comb begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = 8'h00;
        bready = 1'b0;
        case (state_q)
            S_HEAD: begin
                tvalid = 1'b1;
                case (hidx_q)
                    2'd0:    tdata = SYNC;
                    2'd1:    tdata = fr16[7:0];
                    2'd2:    tdata = fr16[15:8];
                    default: tdata = {7'b0, hdr_err_q};
                endcase
            end
            S_DATA: begin
                tvalid = full_q;
                tdata  = full_q ? hold_q[{bidx_q, 3'b000} +: 8] : 8'h00;
                tlast  = last_byte && lat_last_q;
                bready = !full_q || (last_byte && bus.m_tready && !lat_last_q);
            end
            default: ;
        endcase
    end

    assign bus.m_tvalid    = tvalid;
    assign bus.m_tlast     = tlast;
    assign bus.m_tdata     = tdata;
    assign bus.bus_ready_o = bready;
    assign frame_o         = frame_q;
    assign error_o         = error_q;

    assign byte_acc = tvalid && bus.m_tready;
    assign word_acc = bus.bus_valid_i && bready;

    // Length violation: early last, or missing last on the expected final word
    assign err_set = word_acc &&
                     ((bus.bus_last_i && (vcnt_q != VCNT_LW)) ||
                      (!bus.bus_last_i && (vcnt_q == VCNT_LW)));

    // Next-state: frame sequencing, holding register, counters, sticky error
    always_comb begin
        state_d    = state_q;
        hidx_d     = hidx_q;
        hdr_err_d  = hdr_err_q;
        hold_d     = hold_q;
        bidx_d     = bidx_q;
        full_d     = full_q;
        lat_last_d = lat_last_q;
        vcnt_d     = vcnt_q;
        frame_d    = frame_q;
        error_d    = err_set || (error_q && !err_clear_i);
        case (state_q)
            S_IDLE: begin
                if (bus.bus_valid_i) begin
                    state_d   = S_HEAD;
                    hidx_d    = 2'd0;
                    vcnt_d    = '0;
                    hdr_err_d = error_q;
                end
            end
            S_HEAD: begin
                if (byte_acc) begin
                    if (hidx_q == 2'd3) begin
                        state_d = S_DATA;
                        full_d  = 1'b0;
                    end else begin
                        hidx_d = hidx_q + 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (byte_acc) begin
                    if (bidx_q == LAST_B) begin
                        full_d = 1'b0;
                        if (lat_last_q) begin
                            frame_d = frame_q + FBITS'(1);
                            state_d = S_IDLE;
                        end
                    end else begin
                        bidx_d = bidx_q + BW'(1);
                    end
                end
                if (word_acc) begin
                    hold_d     = {bus.bus_imvis_i, bus.bus_revis_i};
                    bidx_d     = '0;
                    full_d     = 1'b1;
                    lat_last_d = bus.bus_last_i;
                    if (vcnt_q != VCNT_SAT) begin
                        vcnt_d = vcnt_q + VW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any partial frame
    always_ff @(posedge bus_clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= S_IDLE;
            hidx_q     <= 2'd0;
            hdr_err_q  <= 1'b0;
            hold_q     <= '0;
            bidx_q     <= '0;
            full_q     <= 1'b0;
            lat_last_q <= 1'b0;
            vcnt_q     <= '0;
            frame_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hidx_q     <= hidx_d;
            hdr_err_q  <= hdr_err_d;
            hold_q     <= hold_d;
            bidx_q     <= bidx_d;
            full_q     <= full_d;
            lat_last_q <= lat_last_d;
            vcnt_q     <= vcnt_d;
            frame_q    <= frame_d;
            error_q    <= error_d;
        end
    end
endmodule
